// File: rtl/inert_seq.sv
// Inertial sensor sequencer: configures the sensor over the SPI monarch port
// after power-up, then reads the yaw-rate low/high bytes on each data-ready.
module inert_seq #(
  parameter logic [15:0] STARTUP_CYC = 16'hFFFF,
  parameter logic [15:0] INIT0_CMD   = 16'h0D02,
  parameter logic [15:0] INIT1_CMD   = 16'h1160,
  parameter logic [15:0] INIT2_CMD   = 16'h1440,
  parameter logic [15:0] RDL_CMD     = 16'hA600,
  parameter logic [15:0] RDH_CMD     = 16'hA700
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] wt_data,
  output logic [15:0] yaw_rt,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    S_STARTUP = 3'd0,
    S_W_I0    = 3'd1,
    S_W_I1    = 3'd2,
    S_W_I2    = 3'd3,
    S_IDLE    = 3'd4,
    S_W_L     = 3'd5,
    S_W_H     = 3'd6
  } state_t;

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_wrt;
  logic [15:0] r_wt_data;
  logic [7:0]  r_low;
  logic [15:0] r_yaw;
  logic        r_vld;
  logic        r_init_done;
  logic        r_int_meta;
  logic        r_int_s;

  state_t      w_state_nxt;
  logic [15:0] w_timer_nxt;
  logic        w_wrt_nxt;
  logic [15:0] w_wt_data_nxt;
  logic [7:0]  w_low_nxt;
  logic [15:0] w_yaw_nxt;
  logic        w_vld_nxt;
  logic        w_init_done_nxt;
  logic        w_unused_hi;

  // Only the low byte of each SPI read carries register data.
  assign w_unused_hi = ^rd_data[15:8];

  // Two-flop synchronizer for the asynchronous data-ready interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_meta <= 1'b0;
      r_int_s    <= 1'b0;
    end else begin
      r_int_meta <= INT;
      r_int_s    <= r_int_meta;
    end
  end

  // Next-state and next-output logic; every command loads wrt and wt_data together.
  always_comb begin
    w_state_nxt     = r_state;
    w_timer_nxt     = r_timer;
    w_wrt_nxt       = 1'b0;
    w_wt_data_nxt   = r_wt_data;
    w_low_nxt       = r_low;
    w_yaw_nxt       = r_yaw;
    w_vld_nxt       = 1'b0;
    w_init_done_nxt = r_init_done;
    case (r_state)
      S_STARTUP: begin
        if (r_timer == STARTUP_CYC) begin
          w_wrt_nxt     = 1'b1;
          w_wt_data_nxt = INIT0_CMD;
          w_state_nxt   = S_W_I0;
        end else begin
          w_timer_nxt = r_timer + 16'd1;
        end
      end
      S_W_I0: begin
        if (done) begin
          w_wrt_nxt     = 1'b1;
          w_wt_data_nxt = INIT1_CMD;
          w_state_nxt   = S_W_I1;
        end else begin
          w_state_nxt = S_W_I0;
        end
      end
      S_W_I1: begin
        if (done) begin
          w_wrt_nxt     = 1'b1;
          w_wt_data_nxt = INIT2_CMD;
          w_state_nxt   = S_W_I2;
        end else begin
          w_state_nxt = S_W_I1;
        end
      end
      S_W_I2: begin
        if (done) begin
          w_init_done_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_state_nxt = S_W_I2;
        end
      end
      S_IDLE: begin
        if (r_int_s) begin
          w_wrt_nxt     = 1'b1;
          w_wt_data_nxt = RDL_CMD;
          w_state_nxt   = S_W_L;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_W_L: begin
        if (done) begin
          w_low_nxt     = rd_data[7:0];
          w_wrt_nxt     = 1'b1;
          w_wt_data_nxt = RDH_CMD;
          w_state_nxt   = S_W_H;
        end else begin
          w_state_nxt = S_W_L;
        end
      end
      S_W_H: begin
        // A pending interrupt here is picked up from IDLE on the next cycle.
        if (done) begin
          w_yaw_nxt   = {rd_data[7:0], r_low};
          w_vld_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_W_H;
        end
      end
      default: begin
        w_state_nxt = S_STARTUP;
        w_timer_nxt = 16'd0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_STARTUP;
      r_timer     <= 16'd0;
      r_wrt       <= 1'b0;
      r_wt_data   <= 16'h0000;
      r_low       <= 8'h00;
      r_yaw       <= 16'h0000;
      r_vld       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_wrt       <= w_wrt_nxt;
      r_wt_data   <= w_wt_data_nxt;
      r_low       <= w_low_nxt;
      r_yaw       <= w_yaw_nxt;
      r_vld       <= w_vld_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign wrt       = r_wrt;
  assign wt_data   = r_wt_data;
  assign yaw_rt    = r_yaw;
  assign vld       = r_vld;
  assign init_done = r_init_done;

endmodule

// File: tb/tb_inert_seq.sv
// Bench for inert_seq: an SPI monarch stand-in answers commands with random
// latency while a transaction-level model predicts command order and samples.
module tb_inert_seq;

  localparam logic [15:0] C_I0 = 16'h0D02;
  localparam logic [15:0] C_I1 = 16'h1160;
  localparam logic [15:0] C_I2 = 16'h1440;
  localparam logic [15:0] C_RL = 16'hA600;
  localparam logic [15:0] C_RH = 16'hA700;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        INT     = 1'b0;
  logic        done    = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] yaw_rt;
  logic        vld;
  logic        init_done;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edges counts clocks since reset release.
  int          edges = 0, m_ncmd = 0, cnt = 0, lat_fixed = 0;
  int          n_a6 = 0, n_a7 = 0, n_vld = 0, a6_edge = 0;
  bit          m_phase, m_init, busy, txn_ok, fix_en;
  logic [15:0] m_yaw = 16'h0000, cur_cmd = 16'h0000;
  logic [7:0]  m_lo = 8'h00, cur_hi = 8'h00, fix_lo = 8'h00, fix_hi = 8'h00;
  logic [15:0] init_tab [3] = '{C_I0, C_I1, C_I2};

  inert_seq #(.STARTUP_CYC(16'd16)) dut (
    .clk       (clk),
    .rst       (rst),
    .INT       (INT),
    .done      (done),
    .rd_data   (rd_data),
    .wrt       (wrt),
    .wt_data   (wt_data),
    .yaw_rt    (yaw_rt),
    .vld       (vld),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic wait_init(input string tag);
    int k = 0;
    while (init_done !== 1'b1 && k < 200) begin
      tick(1);
      k++;
    end
    chk(tag, {31'd0, init_done}, 32'd1);
  endtask

  // SPI responder plus reference model, evaluated on every falling edge.
  initial begin : spi_model
    bit          strobe;
    logic [15:0] expc;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      strobe = 1'b0;
      if (done) begin
        done = 1'b0;
        busy = 1'b0;
        if (txn_ok && !rst) begin
          if (cur_cmd == C_I0) chk("i1_after_done", {15'd0, wrt, wt_data}, {15'd0, 1'b1, C_I1});
          else if (cur_cmd == C_I1) chk("i2_after_done", {15'd0, wrt, wt_data}, {15'd0, 1'b1, C_I2});
          else if (cur_cmd == C_I2) begin
            m_init = 1'b1;
            chk("no_wrt_after_i2", {31'd0, wrt}, 32'd0);
          end else if (cur_cmd == C_RL) chk("rdh_after_rdl", {15'd0, wrt, wt_data}, {15'd0, 1'b1, C_RH});
          else if (cur_cmd == C_RH) begin
            m_yaw  = {cur_hi, m_lo};
            strobe = 1'b1;
            chk("vld_on_rdh_done", {31'd0, vld}, 32'd1);
            chk("no_wrt_with_vld", {31'd0, wrt}, 32'd0);
          end
        end
      end
      if (rst) begin
        edges = 0; m_ncmd = 0; m_phase = 1'b0; m_init = 1'b0;
        m_yaw = 16'h0000; txn_ok = 1'b0;
        chk("rst_ctl", {29'd0, wrt, vld, init_done}, 32'd0);
        chk("rst_wt_data", {16'd0, wt_data}, 32'd0);
        chk("rst_yaw", {16'd0, yaw_rt}, 32'd0);
      end else begin
        edges++;
      end
      if (!rst && wrt) begin
        chk("no_overlap", {31'd0, busy}, 32'd0);
        expc = (m_ncmd < 3) ? init_tab[m_ncmd] : (m_phase ? C_RH : C_RL);
        chk("cmd_order", {16'd0, wt_data}, {16'd0, expc});
        if (m_ncmd == 0) chk("startup_wait", edges, 17);
        if (m_ncmd < 3) m_ncmd++;
        else m_phase = !m_phase;
        if (wt_data == C_RL) begin
          n_a6++;
          a6_edge = edges;
        end
        if (wt_data == C_RH) n_a7++;
        busy    = 1'b1;
        txn_ok  = 1'b1;
        cur_cmd = wt_data;
        cnt     = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 6));
      end else if (busy) begin
        if (txn_ok && !rst) chk("wt_data_hold", {16'd0, wt_data}, {16'd0, cur_cmd});
        cnt--;
        if (cnt == 0) begin
          if (cur_cmd == C_RL) b = fix_en ? fix_lo : 8'($urandom);
          else if (cur_cmd == C_RH) b = fix_en ? fix_hi : 8'($urandom);
          else b = 8'($urandom);
          if (cur_cmd == C_RL && txn_ok) m_lo = b;
          if (cur_cmd == C_RH) cur_hi = b;
          rd_data = {8'($urandom), b};
          done    = 1'b1;
        end
      end
      if (!rst) begin
        if (!strobe) chk("vld_quiet", {31'd0, vld}, 32'd0);
        chk("yaw_value", {16'd0, yaw_rt}, {16'd0, m_yaw});
        chk("init_done", {31'd0, init_done}, {31'd0, m_init});
      end
      if (vld === 1'b1) n_vld++;
    end
  end

  initial begin : main
    int v0, a0, e0, k;
    // Reset state, then startup wait and the three configuration writes.
    tick(3);
    chk("rst_wrt", {31'd0, wrt}, 32'd0);
    rst = 1'b0;
    wait_init("t1_init_done");

    // One interrupt pulse gives one sample assembled from fixed bytes.
    fix_en = 1'b1; fix_lo = 8'h34; fix_hi = 8'h12;
    v0 = n_vld; a0 = n_a6;
    INT = 1'b1; tick(1); INT = 1'b0;
    tick(60);
    chk("t2_one_vld", n_vld - v0, 1);
    chk("t2_one_read_pair", n_a6 - a0, 1);
    chk("t2_yaw", {16'd0, yaw_rt}, 32'h0000_1234);

    // Interrupt held through startup and init is only serviced afterwards.
    INT = 1'b1; a0 = n_a6;
    rst = 1'b1; tick(1); rst = 1'b0;
    wait_init("t3_init_done");
    e0 = edges;
    chk("t3_no_read_in_init", n_a6 - a0, 0);
    k = 0;
    while (n_a6 == a0 && k < 10) begin tick(1); k++; end
    chk("t3_read_soon", {31'd0, (n_a6 > a0) && (a6_edge - e0 >= 1) && (a6_edge - e0 <= 3)}, 32'd1);
    v0 = n_vld; k = 0;
    while (n_vld == v0 && k < 100) begin tick(1); k++; end
    INT = 1'b0;
    chk("t3_vld_seen", {31'd0, n_vld > v0}, 32'd1);
    tick(40);

    // Most negative sample, then confirm it holds between strobes.
    fix_lo = 8'h00; fix_hi = 8'h80;
    INT = 1'b1; tick(1); INT = 1'b0;
    tick(40);
    chk("t4_yaw_neg", {16'd0, yaw_rt}, 32'h0000_8000);
    tick(20);
    chk("t4_yaw_hold", {16'd0, yaw_rt}, 32'h0000_8000);

    // Reset while the high-byte read is outstanding; its done arrives late.
    lat_fixed = 8; v0 = n_vld; a0 = n_a7;
    INT = 1'b1; tick(1); INT = 1'b0;
    k = 0;
    while (n_a7 == a0 && k < 60) begin tick(1); k++; end
    chk("t5_rdh_issued", {31'd0, n_a7 > a0}, 32'd1);
    tick(2);
    rst = 1'b1; tick(1); rst = 1'b0;
    chk("t5_yaw_cleared", {16'd0, yaw_rt}, 32'd0);
    wait_init("t5_init_done");
    tick(5);
    chk("t5_no_vld", n_vld - v0, 0);
    chk("t5_yaw_zero", {16'd0, yaw_rt}, 32'd0);
    lat_fixed = 0; fix_en = 1'b0;

    // Random interrupt traffic with random done latency.
    for (int i = 0; i < 50; i++) begin
      tick($urandom_range(0, 5));
      v0 = n_vld;
      INT = 1'b1;
      k = 0;
      while (n_vld == v0 && k < 300) begin tick(1); k++; end
      chk("t6_serviced", {31'd0, n_vld > v0}, 32'd1);
      INT = 1'b0;
    end
    tick(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
